// File: rtl/ct_spsram_shadow_param.sv
// Single-port SRAM with a bit-accurate taint shadow array, an optional
// output register stage and a hardware clear sequence after reset.
//
// Access protocol: CEN/GWEN/WEN/A/D are sampled on the rising edge of CLK.
// An access is accepted on any edge where INIT_BUSY is low and CEN is low;
// there is no other backpressure. Read data is valid one edge later, or two
// edges later with OUT_REG=1, and then holds until the next read completes.
module ct_spsram_shadow_param #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 128,
  parameter int WE_WIDTH      = 128,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [WE_WIDTH-1:0]   WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  INIT_BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int G     = DATA_WIDTH / WE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;
  logic                    sticky, sticky_next;
  logic                    clr_en, rd_en, wr_en, esc;
  logic [DATA_WIDTH-1:0]   mem    [DEPTH];
  logic [DATA_WIDTH-1:0]   shadow [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q, rd_q_t0;

  // The FSM state is visible to checkers as INIT_BUSY (CLEAR <=> busy).
  assign INIT_BUSY = (state == ST_CLEAR);

  // Any tainted control or address on a read makes the whole word tainted.
  assign esc = (|A_t0) | CEN_t0 | GWEN_t0 | sticky;

  // Next-state logic: clear counter walk, access decode, sticky escalation.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    sticky_next  = sticky;
    clr_en       = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_en = 1'b1;
        // The counter parks at the last entry so it never starts a second pass.
        if (clr_cnt == LAST_ADDR) state_next = ST_READY;
        else clr_cnt_next = clr_cnt + 1'b1;
      end
      ST_READY: begin
        rd_en       = !CEN && GWEN;
        wr_en       = !CEN && !GWEN;
        // Once control/address taint is seen, the tracker can no longer tell
        // which entries were touched, so all later reads are tainted.
        sticky_next = sticky | CEN_t0 | (!CEN & GWEN_t0) | (!CEN & !GWEN & (|A_t0));
      end
      default: state_next = ST_READY;
    endcase
  end

  // State, clear counter and sticky flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
      sticky  <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      sticky  <= sticky_next;
    end
  end

  // Storage and shadow writes; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (clr_en) begin
      mem[clr_cnt]    <= '0;
      shadow[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!WEN[i]) begin
          mem[A][i*G +: G]    <= D[i*G +: G];
          shadow[A][i*G +: G] <= D_t0[i*G +: G] | {G{WEN_t0[i]}};
        end
      end
    end
  end

  // First read stage: captures data and taint only when a read is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q    <= '0;
      rd_q_t0 <= '0;
    end else if (rd_en) begin
      rd_q    <= mem[A];
      rd_q_t0 <= shadow[A] | {DATA_WIDTH{esc}};
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q, out_q_t0;
      // Optional output stage; taint rides the same register as data.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          out_q    <= '0;
          out_q_t0 <= '0;
        end else begin
          out_q    <= rd_q;
          out_q_t0 <= rd_q_t0;
        end
      end
      assign Q    = out_q;
      assign Q_t0 = out_q_t0;
    end else begin : g_no_out_reg
      assign Q    = rd_q;
      assign Q_t0 = rd_q_t0;
    end
  endgenerate

endmodule

// File: tb/tb_ct_spsram_shadow_param.sv
// Directed bench for ct_spsram_shadow_param: two instances (OUT_REG=0 and
// OUT_REG=1) share one stimulus stream so latency is checked side by side.
module tb_ct_spsram_shadow_param;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] a, a_t0;
  logic          cen, cen_t0, gwen, gwen_t0;
  logic [WW-1:0] wen, wen_t0;
  logic [DW-1:0] d, d_t0;
  logic [DW-1:0] q0, q0_t0, q1, q1_t0;
  logic          busy0, busy1;

  ct_spsram_shadow_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(0), .INIT_ON_RESET(1)
  ) u_dut0 (
    .CLK(clk), .RST(rst), .A(a), .A_t0(a_t0), .CEN(cen), .CEN_t0(cen_t0),
    .GWEN(gwen), .GWEN_t0(gwen_t0), .WEN(wen), .WEN_t0(wen_t0),
    .D(d), .D_t0(d_t0), .Q(q0), .Q_t0(q0_t0), .INIT_BUSY(busy0)
  );

  ct_spsram_shadow_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(1), .INIT_ON_RESET(1)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .A(a), .A_t0(a_t0), .CEN(cen), .CEN_t0(cen_t0),
    .GWEN(gwen), .GWEN_t0(gwen_t0), .WEN(wen), .WEN_t0(wen_t0),
    .D(d), .D_t0(d_t0), .Q(q1), .Q_t0(q1_t0), .INIT_BUSY(busy1)
  );

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  int            busy_cycles;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_t_q[$];
  logic [DW-1:0] prev_q, prev_t;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    a = '0; a_t0 = '0; cen = 1'b1; cen_t0 = 1'b0; gwen = 1'b1; gwen_t0 = 1'b0;
    wen = '1; wen_t0 = '0; d = '0; d_t0 = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy0) busy_cycles++;
  endtask

  task automatic wait_clear(input string tag);
    int guard = 0;
    while (busy0 && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd16);
    check({tag, ".busy0_low"}, 32'(busy0), 32'd0);
    check({tag, ".busy1_low"}, 32'(busy1), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [WW-1:0] we_n, input logic [DW-1:0] data_t,
                          input logic [WW-1:0] we_t, input logic [AW-1:0] addr_t);
    a = addr; d = data; wen = we_n; d_t0 = data_t; wen_t0 = we_t; a_t0 = addr_t;
    cen = 1'b0; gwen = 1'b0;
    @(negedge clk);
    set_idle();
  endtask

  // Read at edge n; OUT_REG=0 must update after n, OUT_REG=1 only after n+1.
  task automatic read_check(input string tag, input logic [AW-1:0] addr,
                            input logic [AW-1:0] addr_t, input logic gw_t,
                            input logic [DW-1:0] exp_data, input logic [DW-1:0] exp_taint);
    logic [DW-1:0] cur_q, cur_t;
    a = addr; a_t0 = addr_t; gwen_t0 = gw_t; cen = 1'b0; gwen = 1'b1;
    exp_q.push_back(exp_data);
    exp_t_q.push_back(exp_taint);
    @(negedge clk);
    set_idle();
    cur_q = exp_q.pop_front();
    cur_t = exp_t_q.pop_front();
    check({tag, ".q0"}, q0, cur_q);
    check({tag, ".q0_t0"}, q0_t0, cur_t);
    check({tag, ".q1_early"}, q1, prev_q);
    check({tag, ".q1_t0_early"}, q1_t0, prev_t);
    @(negedge clk);
    check({tag, ".q1"}, q1, cur_q);
    check({tag, ".q1_t0"}, q1_t0, cur_t);
    check({tag, ".q0_hold"}, q0, cur_q);
    prev_q = cur_q;
    prev_t = cur_t;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst = 1'b1;
    prev_q = '0;
    prev_t = '0;
    repeat (3) @(negedge clk);
    check("rst.q0", q0, 32'h0);
    check("rst.q0_t0", q0_t0, 32'h0);
    check("rst.q1", q1, 32'h0);
    check("rst.q1_t0", q1_t0, 32'h0);
    check("rst.busy0", 32'(busy0), 32'd1);
    check("rst.busy1", 32'(busy1), 32'd1);

    // Clear sequence; a read (with CEN taint) and a write during it are ignored.
    rst = 1'b0;
    busy_cycles = busy0 ? 1 : 0;
    a = 4'd5; cen = 1'b0; gwen = 1'b1; cen_t0 = 1'b1;
    tick();
    set_idle();
    check("clr_rd_ignored.q0", q0, 32'h0);
    check("clr_rd_ignored.q0_t0", q0_t0, 32'h0);
    a = 4'd0; d = 32'hFFFF_FFFF; d_t0 = 32'hFFFF_FFFF; wen = 4'b0000; cen = 1'b0; gwen = 1'b0;
    tick();
    set_idle();
    wait_clear("clear1");
    read_check("post_clear5", 4'd5, 4'd0, 1'b0, 32'h0, 32'h0);
    read_check("post_clear0", 4'd0, 4'd0, 1'b0, 32'h0, 32'h0);

    // Partial writes and write-enable taint.
    do_write(4'd3, 32'hAABB_CCDD, 4'b1010, 32'h0000_00FF, 4'b0000, 4'd0);
    read_check("part_wr", 4'd3, 4'd0, 1'b0, 32'h00BB_00DD, 32'h0000_00FF);
    do_write(4'd4, 32'h1122_3344, 4'b0000, 32'h0, 4'b0100, 4'd0);
    read_check("wen_t0", 4'd4, 4'd0, 1'b0, 32'h1122_3344, 32'h00FF_0000);
    do_write(4'd4, 32'h5555_5555, 4'b1110, 32'h0, 4'b1000, 4'd0);
    read_check("wen_t0_masked", 4'd4, 4'd0, 1'b0, 32'h1122_3355, 32'h00FF_0000);

    // Latency and output hold through idle cycles and writes.
    do_write(4'd7, 32'h1234_5678, 4'b0000, 32'h0, 4'b0000, 4'd0);
    read_check("lat", 4'd7, 4'd0, 1'b0, 32'h1234_5678, 32'h0);
    repeat (3) @(negedge clk);
    check("idle_hold.q0", q0, 32'h1234_5678);
    check("idle_hold.q1", q1, 32'h1234_5678);
    do_write(4'd7, 32'hDEAD_BEEF, 4'b0000, 32'h0, 4'b0000, 4'd0);
    @(negedge clk);
    check("wr_hold.q0", q0, 32'h1234_5678);
    check("wr_hold.q1", q1, 32'h1234_5678);
    read_check("lat2", 4'd7, 4'd0, 1'b0, 32'hDEAD_BEEF, 32'h0);

    // Address taint on a read escalates that read only.
    read_check("a_t0_rd", 4'd3, 4'b0010, 1'b0, 32'h00BB_00DD, 32'hFFFF_FFFF);
    read_check("a_t0_once", 4'd3, 4'd0, 1'b0, 32'h00BB_00DD, 32'h0000_00FF);

    // Address taint on a write sets the sticky flag.
    do_write(4'd8, 32'h0BAD_F00D, 4'b0000, 32'h0, 4'b0000, 4'b0001);
    read_check("sticky4", 4'd4, 4'd0, 1'b0, 32'h1122_3355, 32'hFFFF_FFFF);
    read_check("sticky8", 4'd8, 4'd0, 1'b0, 32'h0BAD_F00D, 32'hFFFF_FFFF);

    // Reset while a read is still in the OUT_REG stage.
    a = 4'd3; cen = 1'b0; gwen = 1'b1;
    @(negedge clk);
    set_idle();
    check("midrd.q0_pre", q0, 32'h00BB_00DD);
    rst = 1'b1;
    #1;
    check("midrd.q0", q0, 32'h0);
    check("midrd.q0_t0", q0_t0, 32'h0);
    check("midrd.q1", q1, 32'h0);
    check("midrd.q1_t0", q1_t0, 32'h0);
    @(negedge clk);
    check("midrd.q1_dropped", q1, 32'h0);
    rst = 1'b0;
    busy_cycles = 1;
    prev_q = '0;
    prev_t = '0;
    wait_clear("clear2");
    check("clear2.q1", q1, 32'h0);
    read_check("sticky_clr", 4'd3, 4'd0, 1'b0, 32'h0, 32'h0);

    // GWEN taint on a read escalates that read and sets sticky.
    read_check("gwen_t0_rd", 4'd2, 4'd0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    read_check("gwen_sticky", 4'd2, 4'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);

    // Fill every entry, then reset mid-clear and confirm a full restart.
    for (int k = 0; k < 16; k++)
      do_write(4'(k), 32'hA5A5_0000 | 32'(k), 4'b0000, 32'h0000_FFFF, 4'b0000, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_cycles = 1;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("midclr.busy0", 32'(busy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    busy_cycles = 1;
    prev_q = '0;
    prev_t = '0;
    wait_clear("clear3");
    for (int k = 0; k < 16; k++)
      read_check($sformatf("midclr_rd%0d", k), 4'(k), 4'd0, 1'b0, 32'h0, 32'h0);

    // CEN taint on an idle cycle sets sticky.
    cen_t0 = 1'b1;
    @(negedge clk);
    set_idle();
    read_check("cen_t0_idle", 4'd1, 4'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
